i2c_cmd_queue: RTL and testbench
================================

// Module: i2c_cmd_queue
// PURPOSE
//  Command queue directly upstream of i2c_controller. Buffers PCA9685
//  register read/write commands in a FIFO and issues them one at a time over
//  the controller's execute/busy handshake. Returns read data with a strobe,
//  and flags overflow and handshake timeouts with sticky error bits.
// PARAMETERS
//  DEPTH        8      FIFO entries; power of 2, >= 2
//  DEV_ADDR     7'h40  7-bit I2C target address driven on address_o
//  TIMEOUT      255    max cycles execute_o is held waiting for busy_i rise
// PORTS
//  clk_i            in   1      system clock
//  rst_ni           in   1      asynchronous reset, active low
//  push_i           in   1      enqueue a command this cycle
//  push_rw_i        in   1      1 = read, 0 = write
//  push_reg_i       in   8      register id
//  push_val_i       in   8      write value; ignored for reads
//  full_o           out  1      FIFO holds DEPTH entries
//  empty_o          out  1      FIFO holds 0 entries
//  level_o          out  log2(DEPTH)+1  current entry count
//  idle_o           out  1      FSM in IDLE and FIFO empty
//  rd_valid_o       out  1      1-cycle strobe: read result valid
//  rd_reg_o         out  8      register id of the completed read
//  rd_data_o        out  8      read data
//  overflow_o       out  1      sticky: a push was dropped
//  timeout_o        out  1      sticky: busy_i never rose within TIMEOUT
//  clr_err_i        in   1      clears overflow_o and timeout_o
//  address_o        out  7      to controller address_i, constant DEV_ADDR
//  rw_o             out  1      to controller rw_i
//  register_id_o    out  8      to controller register_id_i
//  register_value_o out  8      to controller register_value_i
//  execute_o        out  1      to controller execute_i
//  busy_i           in   1      from controller busy_o
//  register_value_i in   8      from controller register_value_o
// BEHAVIOUR
//  Reset (async, rst_ni=0): FIFO emptied, FSM to IDLE; execute_o, rd_valid_o,
//   overflow_o, timeout_o, rw_o = 0; register_id_o, register_value_o,
//   rd_reg_o, rd_data_o = 0; empty_o=1, full_o=0, level_o=0, idle_o=1.
//   Reset mid-transaction drops execute_o immediately and discards the entry.
//  FIFO: a push is accepted if !full_o, or if the FSM pops in the same cycle.
//   A push while full with no pop is dropped and sets overflow_o.
//   Pointers wrap modulo DEPTH; level_o updates the cycle after push/pop.
//  FSM states:
//   IDLE:   if !empty_o and busy_i==0, pop the head, latch it into rw_o,
//           register_id_o, register_value_o; go LAUNCH. execute_o rises on
//           the cycle after the pop (1-cycle latency).
//   LAUNCH: execute_o=1, count cycles. On busy_i==1, go RUN. If count reaches
//           TIMEOUT first: execute_o=0, set timeout_o, discard the cmd, go IDLE.
//   RUN:    execute_o=0. On busy_i==0, go DONE.
//   DONE:   if rw_o==1: rd_valid_o=1 for exactly this cycle, with
//           rd_data_o=register_value_i and rd_reg_o=register_id_o captured.
//           Always go IDLE. Back-to-back commands: IDLE->LAUNCH takes 1 cycle.
//  rw_o, register_id_o and register_value_o stay stable from LAUNCH until
//   leaving DONE.
//  clr_err_i and a new error in the same cycle: the new error wins (bit set).
//  Commands are issued strictly in FIFO order; no reordering.
// TESTING
//  1 Reset: assert rst_ni=0 mid-LAUNCH -> execute_o=0 same cycle; level_o=0,
//    idle_o=1 after release.
//  2 Push write reg 8'h06, val 8'h55; model busy 1 after 3 cycles, 0 after 20
//    -> execute_o high 1 cycle after push; drops on busy rise; rd_valid_o
//    never pulses.
//  3 Push read reg 8'h0F; model returns 8'hA5 -> single rd_valid_o pulse with
//    rd_reg_o=8'h0F, rd_data_o=8'hA5.
//  4 Push 9 writes (regs 8'h00..8'h08) while busy_i held 1, DEPTH=8
//    -> full_o=1, 9th dropped, overflow_o=1; release busy -> regs 00..07
//    issued in order; clr_err_i clears overflow_o.
//  5 Push one cmd, never raise busy_i -> execute_o high exactly TIMEOUT
//    cycles, then 0; timeout_o=1; level_o=0; next cmd still issues.
//  6 Full FIFO, push in the same cycle as the IDLE pop -> push accepted,
//    level_o stays 8, overflow_o stays 0.

Source files
------------

// File: rtl/i2c_cmd_queue.sv
// Command FIFO in front of i2c_controller: queues PCA9685 register accesses,
// issues them one at a time over execute/busy and returns read data.
module i2c_cmd_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [6:0]  DEV_ADDR = 7'h40,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       push_rw_i,
    input  logic [7:0]                 push_reg_i,
    input  logic [7:0]                 push_val_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       idle_o,
    output logic                       rd_valid_o,
    output logic [7:0]                 rd_reg_o,
    output logic [7:0]                 rd_data_o,
    output logic                       overflow_o,
    output logic                       timeout_o,
    input  logic                       clr_err_i,
    output logic [6:0]                 address_o,
    output logic                       rw_o,
    output logic [7:0]                 register_id_o,
    output logic [7:0]                 register_value_o,
    output logic                       execute_o,
    input  logic                       busy_i,
    input  logic [7:0]                 register_value_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    logic [16:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nx_s;
    logic          full_r;
    logic          empty_r;
    logic          idle_r;
    state_t        state_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          exec_r;
    logic          rw_r;
    logic [7:0]    reg_id_r;
    logic [7:0]    reg_val_r;
    logic          rd_valid_r;
    logic [7:0]    rd_reg_r;
    logic [7:0]    rd_data_r;
    logic          overflow_r;
    logic          timeout_r;
    logic          pop_s;
    logic          push_ok_s;
    logic          push_drop_s;
    logic          tmo_hit_s;

    // Pop/push arbitration, timeout detection and next FIFO occupancy.
    always_comb begin
        pop_s       = (state_r == ST_IDLE) && !empty_r && !busy_i;
        push_ok_s   = push_i && (!full_r || pop_s);
        push_drop_s = push_i && full_r && !pop_s;
        tmo_hit_s   = (state_r == ST_LAUNCH) && !busy_i &&
                      (tmo_cnt_r == TW'(TIMEOUT - 1));
        count_nx_s  = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nx_s = count_r + (AW+1)'(1'b1);
            2'b01:   count_nx_s = count_r - (AW+1)'(1'b1);
            default: count_nx_s = count_r;
        endcase
    end

    // FIFO storage, pointers and registered occupancy flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= 17'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= {push_rw_i, push_reg_i, push_val_i};
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == (AW+1)'(DEPTH));
            empty_r <= (count_nx_s == (AW+1)'(0));
        end
    end

    // Sticky error flags; a fresh error outranks a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            overflow_r <= push_drop_s | (overflow_r & ~clr_err_i);
            timeout_r  <= tmo_hit_s   | (timeout_r  & ~clr_err_i);
        end
    end

    // Handshake FSM with registered controller-side and read-return outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            tmo_cnt_r  <= '0;
            exec_r     <= 1'b0;
            rw_r       <= 1'b0;
            reg_id_r   <= 8'h00;
            reg_val_r  <= 8'h00;
            rd_valid_r <= 1'b0;
            rd_reg_r   <= 8'h00;
            rd_data_r  <= 8'h00;
            idle_r     <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        {rw_r, reg_id_r, reg_val_r} <= mem_r[rd_ptr_r];
                        exec_r    <= 1'b1;
                        tmo_cnt_r <= '0;
                        state_r   <= ST_LAUNCH;
                        idle_r    <= 1'b0;
                    end else begin
                        exec_r <= 1'b0;
                        idle_r <= (count_nx_s == (AW+1)'(0));
                    end
                end
                ST_LAUNCH: begin
                    if (busy_i) begin
                        exec_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end else if (tmo_hit_s) begin
                        // Controller never answered: abandon this command.
                        exec_r  <= 1'b0;
                        state_r <= ST_IDLE;
                        idle_r  <= (count_nx_s == (AW+1)'(0));
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
                    end
                end
                ST_RUN: begin
                    exec_r <= 1'b0;
                    if (!busy_i) begin
                        state_r <= ST_DONE;
                        if (rw_r) begin
                            rd_valid_r <= 1'b1;
                            rd_reg_r   <= reg_id_r;
                            rd_data_r  <= register_value_i;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    idle_r  <= (count_nx_s == (AW+1)'(0));
                end
                default: begin
                    exec_r  <= 1'b0;
                    state_r <= ST_IDLE;
                    idle_r  <= (count_nx_s == (AW+1)'(0));
                end
            endcase
        end
    end

    assign full_o           = full_r;
    assign empty_o          = empty_r;
    assign level_o          = count_r;
    assign idle_o           = idle_r;
    assign rd_valid_o       = rd_valid_r;
    assign rd_reg_o         = rd_reg_r;
    assign rd_data_o        = rd_data_r;
    assign overflow_o       = overflow_r;
    assign timeout_o        = timeout_r;
    assign address_o        = DEV_ADDR;
    assign rw_o             = rw_r;
    assign register_id_o    = reg_id_r;
    assign register_value_o = reg_val_r;
    assign execute_o        = exec_r;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Self-checking bench for i2c_cmd_queue: vector table, corner sequences and
// randomized bursts against a queue-based model of the expected issue order.
module tb_i2c_cmd_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic       clk_i;
    logic       rst_ni;
    logic       push_i;
    logic       push_rw_i;
    logic [7:0] push_reg_i;
    logic [7:0] push_val_i;
    logic       full_o;
    logic       empty_o;
    logic [3:0] level_o;
    logic       idle_o;
    logic       rd_valid_o;
    logic [7:0] rd_reg_o;
    logic [7:0] rd_data_o;
    logic       overflow_o;
    logic       timeout_o;
    logic       clr_err_i;
    logic [6:0] address_o;
    logic       rw_o;
    logic [7:0] register_id_o;
    logic [7:0] register_value_o;
    logic       execute_o;
    logic       busy_i;
    logic [7:0] register_value_i;

    i2c_cmd_queue #(.DEPTH(DEPTH), .DEV_ADDR(7'h40), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(push_i), .push_rw_i(push_rw_i), .push_reg_i(push_reg_i),
        .push_val_i(push_val_i), .full_o(full_o), .empty_o(empty_o),
        .level_o(level_o), .idle_o(idle_o), .rd_valid_o(rd_valid_o),
        .rd_reg_o(rd_reg_o), .rd_data_o(rd_data_o), .overflow_o(overflow_o),
        .timeout_o(timeout_o), .clr_err_i(clr_err_i), .address_o(address_o),
        .rw_o(rw_o), .register_id_o(register_id_o),
        .register_value_o(register_value_o), .execute_o(execute_o),
        .busy_i(busy_i), .register_value_i(register_value_i)
    );

    int checks = 0;
    int errors = 0;

    // Controller model knobs and observations
    bit  hold_busy = 1'b0;
    bit  resp_en   = 1'b1;
    int  rise_dly  = 2;
    int  busy_len  = 4;
    int  exec_cycles = 0;
    logic [16:0] issued_q[$];
    logic [16:0] exp_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] exp_rd[$];

    typedef struct {
        logic       rw;
        logic [7:0] rg;
        logic [7:0] val;
        int         pulses;
        logic [7:0] data;
    } vec_t;
    vec_t vecs[7];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural i2c_controller: busy rises rise_dly cycles into execute,
    // stays up busy_len cycles; read data is register id XOR 8'hAA.
    initial begin
        int phase;
        int cnt;
        phase = 0;
        cnt = 0;
        busy_i = 1'b0;
        register_value_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #2;
            if (!rst_ni) begin
                busy_i = 1'b0; phase = 0; cnt = 0;
            end else if (hold_busy) begin
                busy_i = 1'b1; phase = 0; cnt = 0;
            end else if (phase == 0) begin
                busy_i = 1'b0;
                if (execute_o && resp_en) begin
                    cnt++;
                    if (cnt >= rise_dly) begin
                        busy_i = 1'b1; phase = 1; cnt = 0;
                        issued_q.push_back({rw_o, register_id_o, register_value_o});
                        register_value_i = register_id_o ^ 8'hAA;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= busy_len) begin
                    busy_i = 1'b0; phase = 0; cnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (execute_o) exec_cycles++;
            if (rd_valid_o) rd_q.push_back({rd_reg_o, rd_data_o});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [7:0] rg, input logic [7:0] v);
        push_i = 1'b1; push_rw_i = rw; push_reg_i = rg; push_val_i = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push1(input logic rw, input logic [7:0] rg, input logic [7:0] v);
        @(posedge clk_i);
        #1;
        drive(rw, rg, v);
        push_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!idle_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, 32'(idle_o), 32'd1);
    endtask

    task automatic clr_errors();
        @(posedge clk_i);
        #1 clr_err_i = 1'b1;
        @(posedge clk_i);
        #1 clr_err_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic chk_issued(input string name);
        chk({name, "_count"}, 32'(issued_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++)
            chk({name, "_cmd"}, 32'(issued_q[i]), 32'(exp_q[i]));
    endtask

    task automatic chk_reads(input string name);
        chk({name, "_rdcount"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            chk({name, "_rddata"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    endtask

    task automatic clear_obs();
        issued_q.delete(); exp_q.delete(); rd_q.delete(); exp_rd.delete();
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 8'h06, 8'h55, 0, 8'h00};
        vecs[1] = '{1'b1, 8'h0F, 8'h00, 1, 8'hA5};
        vecs[2] = '{1'b1, 8'h00, 8'h33, 1, 8'hAA};
        vecs[3] = '{1'b0, 8'hFF, 8'h00, 0, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 8'h12, 1, 8'h55};
        vecs[5] = '{1'b1, 8'h80, 8'h00, 1, 8'h2A};
        vecs[6] = '{1'b0, 8'h80, 8'h7F, 0, 8'h00};

        rst_ni = 1'b0; push_i = 1'b0; push_rw_i = 1'b0; push_reg_i = 8'h00;
        push_val_i = 8'h00; clr_err_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_execute", 32'(execute_o), 32'd0);
        chk("rst_flags", 32'({rd_valid_o, overflow_o, timeout_o, rw_o, full_o}), 32'd0);
        chk("rst_data", 32'({register_id_o, register_value_o, rd_reg_o, rd_data_o}), 32'd0);
        chk("rst_empty_idle", 32'({empty_o, idle_o}), 32'h3);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("address", 32'(address_o), 32'h40);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset while execute_o is high
        resp_en = 1'b0;
        push1(1'b0, 8'h11, 8'h22);
        n = 0;
        while (!execute_o && n < 10) begin @(negedge clk_i); n++; end
        chk("launch_before_reset", 32'(execute_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("reset_drops_execute", 32'(execute_o), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        resp_en = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_reset_level", 32'(level_o), 32'd0);
        chk("post_reset_idle", 32'(idle_o), 32'd1);
        chk("post_reset_timeout", 32'(timeout_o), 32'd0);

        // Write: busy after 3 cycles, held 20
        clear_obs();
        rise_dly = 3; busy_len = 20;
        push1(1'b0, 8'h06, 8'h55);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("write_execute_rise", 32'(execute_o), 32'd1);
        n = 0;
        while (!busy_i && n < 20) begin @(negedge clk_i); n++; end
        chk("write_busy_seen", 32'(busy_i), 32'd1);
        chk("write_execute_until_sampled", 32'(execute_o), 32'd1);
        @(negedge clk_i);
        chk("write_execute_drop", 32'(execute_o), 32'd0);
        wait_idle("write_idle", 200);
        exp_q.push_back({1'b0, 8'h06, 8'h55});
        chk_issued("write");
        chk_reads("write");

        // Read of register 0x0F
        clear_obs();
        rise_dly = 3; busy_len = 5;
        push1(1'b1, 8'h0F, 8'h00);
        wait_idle("read_idle", 200);
        exp_q.push_back({1'b1, 8'h0F, 8'h00});
        exp_rd.push_back({8'h0F, 8'hA5});
        chk_issued("read");
        chk_reads("read");

        // Table of single commands
        rise_dly = 2; busy_len = 4;
        for (int v = 0; v < 7; v++) begin
            clear_obs();
            push1(vecs[v].rw, vecs[v].rg, vecs[v].val);
            wait_idle("vec_idle", 200);
            exp_q.push_back({vecs[v].rw, vecs[v].rg, vecs[v].val});
            chk_issued("vec");
            chk("vec_pulses", 32'(rd_q.size()), 32'(vecs[v].pulses));
            if (rd_q.size() > 0)
                chk("vec_rdata", 32'(rd_q[0]), 32'({vecs[v].rg, vecs[v].data}));
        end

        // Overflow: 9 pushes while controller busy
        clear_obs();
        hold_busy = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 8'(i), 8'(i + 16));
            if (i < 8) exp_q.push_back({1'b0, 8'(i), 8'(i + 16)});
        end
        push_i = 1'b0;
        @(negedge clk_i);
        chk("ovf_full", 32'(full_o), 32'd1);
        chk("ovf_level", 32'(level_o), 32'd8);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        hold_busy = 1'b0;
        wait_idle("ovf_drain", 1000);
        chk_issued("ovf_order");
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        clr_errors();
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // Push in the same cycle as the pop from a full FIFO
        clear_obs();
        hold_busy = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h20 + i), 8'(i));
            exp_q.push_back({1'b1, 8'(8'h20 + i), 8'(i)});
            exp_rd.push_back({8'(8'h20 + i), 8'(8'h20 + i) ^ 8'hAA});
        end
        push_i = 1'b0;
        @(negedge clk_i);
        chk("simul_full_before", 32'(level_o), 32'd8);
        @(posedge clk_i);
        #1 hold_busy = 1'b0;
        drive(1'b0, 8'h28, 8'h99);
        push_i = 1'b0;
        exp_q.push_back({1'b0, 8'h28, 8'h99});
        @(negedge clk_i);
        chk("simul_level", 32'(level_o), 32'd8);
        chk("simul_overflow", 32'(overflow_o), 32'd0);
        wait_idle("simul_drain", 1000);
        chk_issued("simul_order");
        chk_reads("simul");

        // Timeout: controller never raises busy
        clear_obs();
        resp_en = 1'b0;
        @(posedge clk_i);
        #1 exec_cycles = 0;
        push1(1'b0, 8'h01, 8'h02);
        wait_idle("tmo_idle", 1000);
        chk("tmo_exec_cycles", 32'(exec_cycles), 32'(TIMEOUT));
        chk("tmo_flag", 32'(timeout_o), 32'd1);
        chk("tmo_level", 32'(level_o), 32'd0);
        chk("tmo_not_issued", 32'(issued_q.size()), 32'd0);
        resp_en = 1'b1;
        push1(1'b0, 8'h02, 8'h03);
        wait_idle("tmo_next_idle", 200);
        exp_q.push_back({1'b0, 8'h02, 8'h03});
        chk_issued("tmo_next");
        chk("tmo_sticky", 32'(timeout_o), 32'd1);
        clr_errors();
        chk("tmo_cleared", 32'(timeout_o), 32'd0);

        // Randomized bursts against the queue model
        for (int r = 0; r < 6; r++) begin
            int cnt;
            clear_obs();
            rise_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 5);
            cnt = $urandom_range(1, DEPTH);
            @(posedge clk_i);
            #1;
            for (int i = 0; i < cnt; i++) begin
                logic       rw;
                logic [7:0] rg;
                logic [7:0] vl;
                rw = 1'($urandom_range(0, 1));
                rg = 8'($urandom);
                vl = 8'($urandom);
                drive(rw, rg, vl);
                exp_q.push_back({rw, rg, vl});
                if (rw) exp_rd.push_back({rg, rg ^ 8'hAA});
            end
            push_i = 1'b0;
            wait_idle("rand_idle", 2000);
            chk_issued("rand");
            chk_reads("rand");
            chk("rand_no_errors", 32'({overflow_o, timeout_o}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
